// File: rtl/phase_to_freq.sv
// Converts a 32-bit NCO phase increment back to an integer frequency in Hz:
// round(phase_word * CLK_HZ / 2^32), computed with a 32-step shift-add multiplier.
module phase_to_freq #(
    parameter int unsigned CLK_HZ = 122880000,
    parameter int unsigned PW     = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [PW-1:0] phase_word,
    input  logic          phase_valid,
    output logic          ready,
    output logic [31:0]   frequency_HZ,
    output logic          freq_valid
);

    localparam int unsigned ACC_W = 60;
    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MULT  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PW - 1);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    sr_q, sr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mc_q, mc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      freq_q, freq_d;
    logic             fvld_q, fvld_d;

    // Half-up rounding: add 2^31 and keep bits [63:32]. The product is below
    // 2^59, so the 64-bit sum never carries past the result field.
    logic [63:0] round_sum;
    logic        unused_round_lo;

    assign round_sum       = {{(64-ACC_W){1'b0}}, acc_q} + 64'h0000_0000_8000_0000;
    assign unused_round_lo = ^round_sum[31:0];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        fvld_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (phase_valid) begin
                    sr_d    = phase_word;
                    acc_d   = '0;
                    mc_d    = ACC_W'(CLK_HZ);
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                if (sr_q[0]) begin
                    acc_d = acc_q + mc_q;
                end
                sr_d  = sr_q >> 1;
                mc_d  = mc_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                freq_d  = round_sum[63:32];
                fvld_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            fvld_q  <= fvld_d;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign frequency_HZ = freq_q;
    assign freq_valid   = fvld_q;

endmodule

// File: tb/tb_phase_to_freq.sv
// Directed and random checks for phase_to_freq: fixed points, handshake,
// streaming, mid-operation reset and a reference-model round trip.
module tb_phase_to_freq;

    localparam longint unsigned CLK = 122880000;

    typedef struct {
        logic [31:0] pw;
        logic [31:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] phase_word = '0;
    logic        phase_valid = 1'b0;
    logic        ready;
    logic [31:0] frequency_HZ;
    logic        freq_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    phase_to_freq #(.CLK_HZ(122880000), .PW(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .phase_word   (phase_word),
        .phase_valid  (phase_valid),
        .ready        (ready),
        .frequency_HZ (frequency_HZ),
        .freq_valid   (freq_valid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (freq_valid) pulses <= pulses + 1;

    function automatic logic [31:0] ref_f(input logic [31:0] pw);
        return 32'(((64'(pw) * CLK) + 64'h8000_0000) >> 32);
    endfunction

    function automatic logic [31:0] stream_w(input int i);
        return 32'(32'h0123_4567 * (i + 1) + i);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Called just after an edge; the request is accepted at the next edge.
    task automatic start(input logic [31:0] pw);
        phase_valid = 1'b1;
        phase_word  = pw;
        @(posedge clock);
        #1 phase_valid = 1'b0;
    endtask

    task automatic wait_res(input int maxe, output int lat, output logic [31:0] val, output bit got);
        lat = 0; got = 0; val = '0;
        while (lat < maxe) begin
            @(posedge clock);
            #1;
            lat++;
            if (freq_valid) begin
                got = 1;
                val = frequency_HZ;
                break;
            end
        end
    endtask

    initial begin
        vec_t        vecs[7];
        int          lat, p0, nres;
        logic [31:0] val, held;
        bit          got;

        vecs[0] = '{32'h0000_0000, 32'd0};
        vecs[1] = '{32'h0000_0001, 32'd0};
        vecs[2] = '{32'h0000_0023, 32'd1};
        vecs[3] = '{32'h1000_0000, 32'd7680000};
        vecs[4] = '{32'h4000_0000, 32'd30720000};
        vecs[5] = '{32'h8000_0000, 32'd61440000};
        vecs[6] = '{32'hFFFF_FFFF, 32'd122880000};

        // Post-reset idle
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_ready", ready, 1);
        check("reset_fvalid", freq_valid, 0);
        check("reset_freq", frequency_HZ, 0);
        p0 = pulses;
        repeat (100) @(posedge clock);
        #1;
        check("idle_no_pulse", pulses - p0, 0);

        // Fixed points
        for (int i = 0; i < 7; i++) begin
            check($sformatf("v%0d_ready", i), ready, 1);
            start(vecs[i].pw);
            check($sformatf("v%0d_busy", i), ready, 0);
            wait_res(40, lat, val, got);
            check($sformatf("v%0d_got", i), got, 1);
            check($sformatf("v%0d_latency", i), lat, 33);
            check($sformatf("v%0d_value", i), val, vecs[i].exp);
            check($sformatf("v%0d_ready_on_pulse", i), ready, 1);
        end

        // Output holds between results
        held = frequency_HZ;
        repeat (10) @(posedge clock);
        #1;
        check("hold_value", frequency_HZ, held);
        check("hold_no_pulse", freq_valid, 0);

        // Handshake: request during MULT is dropped
        p0 = pulses;
        start(32'h4000_0000);
        repeat (4) @(posedge clock);
        #1;
        check("hs_busy", ready, 0);
        phase_valid = 1'b1;
        phase_word  = 32'h8000_0000;
        @(posedge clock);
        #1 phase_valid = 1'b0;
        wait_res(40, lat, val, got);
        check("hs_first_lat", lat, 28);
        check("hs_first_val", val, 30720000);
        start(32'h8000_0000);
        wait_res(40, lat, val, got);
        check("hs_second_lat", lat, 33);
        check("hs_second_val", val, 61440000);
        @(negedge clock);
        #1;
        check("hs_pulse_count", pulses - p0, 2);
        @(posedge clock);
        #1;

        // Streaming: phase_valid held high, word changes every cycle
        phase_valid = 1'b1;
        nres = 0;
        for (int i = 0; i < 102; i++) begin
            phase_word = stream_w(i);
            @(posedge clock);
            #1;
            if (freq_valid) begin
                check("stream_spacing", i - 33, 34 * nres);
                check("stream_value", frequency_HZ, ref_f(stream_w(34 * nres)));
                nres++;
            end
        end
        phase_valid = 1'b0;
        check("stream_count", nres, 3);
        repeat (40) @(posedge clock);
        #1;

        // Reset mid-operation
        p0 = pulses;
        start(32'h4000_0000);
        repeat (14) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_freq", frequency_HZ, 0);
        check("rst_fvalid", freq_valid, 0);
        repeat (40) @(posedge clock);
        #1;
        check("rst_no_pulse", pulses - p0, 0);
        start(32'h1000_0000);
        wait_res(40, lat, val, got);
        check("rst_next_lat", lat, 33);
        check("rst_next_val", val, 7680000);

        // Random round trip
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] pw;
            pw = $urandom;
            start(pw);
            wait_res(40, lat, val, got);
            check("rand_got", got, 1);
            check("rand_val", val, ref_f(pw));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
